ahb5_slave_mem: RTL and testbench

AHB5_SLAVE_MEM -- requirements
Module: ahb5_slave_mem

---
 rtl/ahb5_slave_mem_pkg.sv | 38 +++
 rtl/ahb5_slave_mem_if.sv | 26 ++
 rtl/ahb5_mem_array.sv | 27 ++
 rtl/ahb5_slave_mem.sv | 137 +++++++++++++
 tb/tb_ahb5_slave_mem.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb5_slave_mem_pkg.sv
// Shared AHB5 encodings and slave FSM states for the ahb5_slave_mem slice.
// byteEnable maps the transfer size and the low address bits onto little-endian byte lanes.
package ahb5_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    function automatic logic [3:0] byteEnable(input logic [2:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << offset;
            HSIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb5_slave_mem_if.sv
// AHB5 bus signals seen by one slave; HREADY is the bus-level ready fed back by the interconnect.
interface ahb5_slave_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HNONSEC;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HNONSEC, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HNONSEC, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb5_mem_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
// Contents are deliberately not reset.
module ahb5_mem_array #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          Hclk,
    input  logic [3:0]    i_byteEn,
    input  logic [AW-1:0] i_wrAddr,
    input  logic [31:0]   i_wrData,
    input  logic [AW-1:0] i_rdAddr,
    output logic [31:0]   o_rdData
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge Hclk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_byteEn[i]) begin
                r_mem[i_wrAddr][8*i +: 8] <= i_wrData[8*i +: 8];
            end
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 memory slave: optional wait states, two-cycle ERROR response, pipelined address/data phases.
// A data phase is "pending" while the registered transfer is OKAY and not yet completed.
module ahb5_slave_mem
    import ahb5_pkg::*;
#(
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            Hclk,
    input  logic            HReset,
    ahb5_slave_mem_if.slave bus
);

    localparam int ADDR_W  = $clog2(MEM_BYTES);
    localparam int WORD_AW = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int WORDS   = MEM_BYTES / 4;

    state_t       r_state;
    state_t       w_nextState;
    logic [2:0]   r_count;
    logic [2:0]   w_nextCount;
    logic [31:0]  r_addr;
    logic         r_write;
    logic [2:0]   r_size;
    logic         r_pending;

    logic         w_accept;
    logic         w_sizeBad;
    logic         w_misaligned;
    logic         w_outOfRange;
    logic         w_err;
    logic         w_readyOut;
    logic         w_resp;
    logic         w_complete;
    logic [3:0]   w_byteEn;
    logic [WORD_AW-1:0] w_wordAddr;
    logic [31:0]  w_memRdata;
    logic         w_unused;

    assign w_accept     = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign w_sizeBad    = bus.HSIZE > HSIZE_WORD;
    assign w_misaligned = ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0]) ||
                          ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00));
    assign w_outOfRange = bus.HADDR >= 32'(MEM_BYTES);
    assign w_err        = w_sizeBad || w_misaligned || w_outOfRange;

    always_ff @(posedge Hclk or posedge HReset) begin
        if (HReset) begin
            r_state <= ST_IDLE;
            r_count <= 3'd0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_readyOut  = 1'b1;
        w_resp      = HRESP_OKAY;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                if (r_state == ST_ERR2) begin
                    w_resp = HRESP_ERROR;
                end
                w_nextState = ST_IDLE;
                if (w_accept) begin
                    if (w_err) begin
                        w_nextState = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_nextState = ST_WAIT;
                        w_nextCount = 3'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                w_readyOut = 1'b0;
                if (r_count == 3'd0) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextCount = r_count - 3'd1;
                end
            end
            ST_ERR1: begin
                w_readyOut  = 1'b0;
                w_resp      = HRESP_ERROR;
                w_nextState = ST_ERR2;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Address-phase capture happens only while we drive HREADYOUT high (data phase ending).
    always_ff @(posedge Hclk or posedge HReset) begin
        if (HReset) begin
            r_addr    <= 32'd0;
            r_write   <= 1'b0;
            r_size    <= 3'd0;
            r_pending <= 1'b0;
        end else if (w_readyOut) begin
            if (w_accept) begin
                r_addr    <= bus.HADDR;
                r_write   <= bus.HWRITE;
                r_size    <= bus.HSIZE;
                r_pending <= !w_err;
            end else begin
                r_pending <= 1'b0;
            end
        end
    end

    assign w_complete = (r_state == ST_IDLE) && r_pending;
    assign w_byteEn   = (w_complete && r_write) ? byteEnable(r_size, r_addr[1:0]) : 4'b0000;
    assign w_wordAddr = WORD_AW'(r_addr >> 2);

    ahb5_mem_array #(
        .WORDS (WORDS),
        .AW    (WORD_AW)
    ) u_memArray (
        .Hclk     (Hclk),
        .i_byteEn (w_byteEn),
        .i_wrAddr (w_wordAddr),
        .i_wrData (bus.HWDATA),
        .i_rdAddr (w_wordAddr),
        .o_rdData (w_memRdata)
    );

    assign bus.HREADYOUT = w_readyOut;
    assign bus.HRESP     = w_resp;
    assign bus.HRDATA    = (w_complete && !r_write) ? w_memRdata : 32'h0;

    assign w_unused = &{1'b0, bus.HBURST, bus.HPROT, bus.HNONSEC, bus.HTRANS[0]};

endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Directed and randomized bench for ahb5_slave_mem, driving a zero-wait and a three-wait instance
// against a byte-array model of memory contents and the expected response timing.
module tb_ahb5_slave_mem;
    import ahb5_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        mSel;
    logic        mWrite;
    logic [1:0]  mTrans;
    logic [2:0]  mSize;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    int          target;

    ahb5_slave_mem_if bus0();
    ahb5_slave_mem_if bus3();

    assign bus0.HSEL    = mSel && (target == 0);
    assign bus0.HADDR   = mAddr;
    assign bus0.HTRANS  = mTrans;
    assign bus0.HWRITE  = mWrite;
    assign bus0.HSIZE   = mSize;
    assign bus0.HBURST  = 3'b000;
    assign bus0.HPROT   = 4'b0011;
    assign bus0.HNONSEC = 1'b0;
    assign bus0.HWDATA  = mWdata;
    assign bus0.HREADY  = bus0.HREADYOUT;

    assign bus3.HSEL    = mSel && (target == 3);
    assign bus3.HADDR   = mAddr;
    assign bus3.HTRANS  = mTrans;
    assign bus3.HWRITE  = mWrite;
    assign bus3.HSIZE   = mSize;
    assign bus3.HBURST  = 3'b001;
    assign bus3.HPROT   = 4'b1111;
    assign bus3.HNONSEC = 1'b1;
    assign bus3.HWDATA  = mWdata;
    assign bus3.HREADY  = bus3.HREADYOUT;

    ahb5_slave_mem #(.MEM_BYTES(1024), .WAIT_STATES(0)) dut0 (
        .Hclk   (clock),
        .HReset (reset),
        .bus    (bus0.slave)
    );

    ahb5_slave_mem #(.MEM_BYTES(1024), .WAIT_STATES(3)) dut3 (
        .Hclk   (clock),
        .HReset (reset),
        .bus    (bus3.slave)
    );

    logic        tReady;
    logic        tResp;
    logic [31:0] tRdata;
    assign tReady = (target == 0) ? bus0.HREADYOUT : bus3.HREADYOUT;
    assign tResp  = (target == 0) ? bus0.HRESP     : bus3.HRESP;
    assign tRdata = (target == 0) ? bus0.HRDATA    : bus3.HRDATA;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [2][1024];

    function automatic int mi(input int dut);
        return (dut == 0) ? 0 : 1;
    endfunction

    function automatic bit isErr(input logic [31:0] a, input logic [2:0] s);
        int unsigned n;
        if (s > 3'd2) return 1'b1;
        n = 32'd1 << s;
        if ((a % n) != 0) return 1'b1;
        if (a >= 32'd1024) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelWrite(input int dut, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int unsigned b;
        for (int i = 0; i < (1 << s); i++) begin
            b = a + 32'(i);
            model[mi(dut)][b] = d[8*(b%4) +: 8];
        end
    endtask

    function automatic logic [31:0] modelRead(input int dut, input logic [31:0] a);
        int unsigned base;
        base = a - (a % 4);
        return {model[mi(dut)][base+3], model[mi(dut)][base+2], model[mi(dut)][base+1], model[mi(dut)][base]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer, entered and left at posedge+1 with the target slave ready.
    task automatic applyStimulus(input int dut, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata, output logic [31:0] rdata, output int waits,
                                 output logic resp, output logic lowResp);
        bit done;
        target = dut;
        mSel   = 1'b1;
        mTrans = HTRANS_NONSEQ;
        mAddr  = addr;
        mWrite = wr;
        mSize  = size;
        @(posedge clock); #1;
        mSel    = 1'b0;
        mTrans  = HTRANS_IDLE;
        mWdata  = wdata;
        waits   = 0;
        done    = 1'b0;
        rdata   = 32'hx;
        resp    = 1'bx;
        lowResp = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clock);
            if (tReady) begin
                done  = 1'b1;
                rdata = tRdata;
                resp  = tResp;
            end else begin
                waits++;
                lowResp = lowResp | tResp;
            end
            @(posedge clock); #1;
        end
        checkOutput("xfer_timeout", 32'(done), 32'd1);
    endtask

    logic [31:0] rd;
    int          wt;
    logic        rs;
    logic        lr;
    logic [31:0] pipeData [4];

    initial begin
        mSel = 1'b0; mTrans = HTRANS_IDLE; mWrite = 1'b0; mSize = 3'd0;
        mAddr = 32'd0; mWdata = 32'd0; target = 0;

        @(negedge clock);
        checkOutput("rst0_ready", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("rst0_resp",  32'(bus0.HRESP),     32'd0);
        checkOutput("rst0_rdata", bus0.HRDATA,         32'd0);
        checkOutput("rst3_ready", 32'(bus3.HREADYOUT), 32'd1);
        checkOutput("rst3_resp",  32'(bus3.HRESP),     32'd0);
        checkOutput("rst3_rdata", bus3.HRDATA,         32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        $display("[TB] preloading low 256 bytes of both instances");
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a += 4) begin
                logic [31:0] w;
                w = $urandom;
                applyStimulus(d * 3, 1'b1, 32'(a), HSIZE_WORD, w, rd, wt, rs, lr);
                modelWrite(d * 3, 32'(a), HSIZE_WORD, w);
            end
        end

        $display("[TB] pipelined write then read at 0x10");
        target = 0;
        mSel = 1'b1; mTrans = HTRANS_NONSEQ; mWrite = 1'b1; mAddr = 32'h10; mSize = HSIZE_WORD;
        @(posedge clock); #1;
        mWrite = 1'b0; mWdata = 32'hDEADBEEF;
        @(negedge clock);
        checkOutput("pipe_wr_ready", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("pipe_wr_resp",  32'(bus0.HRESP),     32'd0);
        @(posedge clock); #1;
        mSel = 1'b0; mTrans = HTRANS_IDLE;
        modelWrite(0, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
        @(negedge clock);
        checkOutput("pipe_rd_ready", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("pipe_rd_data",  bus0.HRDATA,         32'hDEADBEEF);
        @(posedge clock); #1;

        $display("[TB] back-to-back burst of four writes then four reads");
        for (int i = 0; i < 4; i++) pipeData[i] = $urandom;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                mSel   = 1'b1;
                mTrans = (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                mWrite = (i < 4);
                mAddr  = 32'h80 + 32'(4 * (i % 4));
                mSize  = HSIZE_WORD;
            end else begin
                mSel = 1'b0; mTrans = HTRANS_IDLE;
            end
            if (i >= 1 && i <= 4) mWdata = pipeData[i-1];
            @(negedge clock);
            if (i >= 1) begin
                checkOutput("burst_ready", 32'(bus0.HREADYOUT), 32'd1);
                if (i <= 4) modelWrite(0, 32'h80 + 32'(4 * (i - 1)), HSIZE_WORD, pipeData[i-1]);
                else checkOutput("burst_rdata", bus0.HRDATA, modelRead(0, 32'h80 + 32'(4 * (i - 5))));
            end
            @(posedge clock); #1;
        end

        $display("[TB] byte lane write at 0x21");
        applyStimulus(0, 1'b1, 32'h21, HSIZE_BYTE, 32'h5A5AAA5A, rd, wt, rs, lr);
        modelWrite(0, 32'h21, HSIZE_BYTE, 32'h5A5AAA5A);
        applyStimulus(0, 1'b0, 32'h20, HSIZE_WORD, 32'h0, rd, wt, rs, lr);
        checkOutput("lane_word",  rd,               modelRead(0, 32'h20));
        checkOutput("lane_byte1", 32'(rd[15:8]),    32'hAA);

        $display("[TB] three wait states on read of 0x0");
        applyStimulus(3, 1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, wt, rs, lr);
        checkOutput("wait_cycles", 32'(wt), 32'd3);
        checkOutput("wait_rdata",  rd,      modelRead(3, 32'h0));
        checkOutput("wait_resp",   32'(rs), 32'd0);

        $display("[TB] error responses");
        applyStimulus(0, 1'b1, 32'h400, HSIZE_WORD, 32'h11111111, rd, wt, rs, lr);
        checkOutput("err_oor_low",   32'(wt), 32'd1);
        checkOutput("err_oor_err1",  32'(lr), 32'd1);
        checkOutput("err_oor_err2",  32'(rs), 32'd1);
        checkOutput("err_oor_rdata", rd,      32'd0);
        applyStimulus(0, 1'b1, 32'h3, HSIZE_HALF, 32'h22222222, rd, wt, rs, lr);
        checkOutput("err_mis_low",   32'(wt), 32'd1);
        checkOutput("err_mis_err2",  32'(rs), 32'd1);
        applyStimulus(0, 1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, wt, rs, lr);
        checkOutput("err_mem_kept",  rd,      modelRead(0, 32'h0));
        applyStimulus(3, 1'b1, 32'h8, 3'd3, 32'h33333333, rd, wt, rs, lr);
        checkOutput("err_size_low",  32'(wt), 32'd1);
        checkOutput("err_size_err2", 32'(rs), 32'd1);

        $display("[TB] BUSY with HSEL high");
        target = 0;
        mSel = 1'b1; mTrans = HTRANS_BUSY; mWrite = 1'b1; mAddr = 32'h10; mSize = HSIZE_WORD;
        mWdata = 32'hCAFEF00D;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checkOutput("busy_ready", 32'(bus0.HREADYOUT), 32'd1);
            checkOutput("busy_resp",  32'(bus0.HRESP),     32'd0);
            @(posedge clock); #1;
        end
        mSel = 1'b0; mTrans = HTRANS_IDLE;
        applyStimulus(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, wt, rs, lr);
        checkOutput("busy_mem_kept", rd, modelRead(0, 32'h10));

        $display("[TB] reset during a wait-state write");
        target = 3;
        mSel = 1'b1; mTrans = HTRANS_NONSEQ; mWrite = 1'b1; mAddr = 32'h40; mSize = HSIZE_WORD;
        @(posedge clock); #1;
        mSel = 1'b0; mTrans = HTRANS_IDLE; mWdata = 32'h12345678;
        @(negedge clock);
        checkOutput("rstw_in_wait", 32'(bus3.HREADYOUT), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("rstw_ready", 32'(bus3.HREADYOUT), 32'd1);
            checkOutput("rstw_resp",  32'(bus3.HRESP),     32'd0);
            checkOutput("rstw_rdata", bus3.HRDATA,         32'd0);
            @(posedge clock); #1;
        end
        reset = 1'b0;
        applyStimulus(3, 1'b0, 32'h40, HSIZE_WORD, 32'h0, rd, wt, rs, lr);
        checkOutput("rstw_mem_kept", rd, modelRead(3, 32'h40));

        $display("[TB] randomized transfers");
        for (int n = 0; n < 160; n++) begin
            int          d;
            bit          wr;
            bit          e;
            logic [2:0]  s;
            logic [31:0] a;
            logic [31:0] data;
            d    = ($urandom_range(0, 1) == 0) ? 0 : 3;
            wr   = 1'($urandom_range(0, 1));
            s    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a    = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 1300)) : 32'($urandom_range(0, 255));
            data = $urandom;
            e    = isErr(a, s);
            applyStimulus(d, wr, a, s, data, rd, wt, rs, lr);
            checkOutput("rand_resp",  32'(rs), 32'(e));
            checkOutput("rand_waits", 32'(wt), e ? 32'd1 : ((d == 0) ? 32'd0 : 32'd3));
            checkOutput("rand_lowrs", 32'(lr), 32'(e));
            if (e) checkOutput("rand_err_rdata", rd, 32'd0);
            else if (!wr) checkOutput("rand_rdata", rd, modelRead(d, a));
            else modelWrite(d, a, s, data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
